// File: rtl/row_serializer_pkg.sv
// Shared types and constants for the row serializer output stage.
// Optional build macro: ROW_SERIALIZER_DOUBLE_BUFFER_EN (consumed by row_serializer.sv).
package row_serializer_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND
    } state_e;

    localparam int DEFAULT_IO_DATA_WIDTH = 16;
    localparam int DEFAULT_NUM_LANES     = 3;
    localparam int DEFAULT_LANE_IDX_W    = $clog2(DEFAULT_NUM_LANES);

    function automatic int lane_idx_w(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

endpackage

// File: rtl/row_serializer_bank.sv
// Bank of NUM_LANES word registers: parallel load from a packed frame, one-word read by lane index.
// Unaffected by ROW_SERIALIZER_DOUBLE_BUFFER_EN; the top instantiates it once or twice.
module serializer_bank
    import row_serializer_pkg::*;
#(
    parameter int IO_DATA_WIDTH = DEFAULT_IO_DATA_WIDTH,
    parameter int NUM_LANES     = DEFAULT_NUM_LANES,
    parameter int IDX_W         = lane_idx_w(NUM_LANES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               load,
    input  logic [NUM_LANES*IO_DATA_WIDTH-1:0] load_words,
    input  logic [IDX_W-1:0]                   sel,
    output logic [IO_DATA_WIDTH-1:0]           rd_word
);

    logic [IO_DATA_WIDTH-1:0] lane_q [NUM_LANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) lane_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < NUM_LANES; i++) lane_q[i] <= load_words[i*IO_DATA_WIDTH +: IO_DATA_WIDTH];
        end
    end

    // Explicit compare mux keeps out-of-range sel codes (non power-of-two lane counts) at zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (sel == IDX_W'(i)) rd_word = lane_q[i];
        end
    end

endmodule

// File: rtl/row_serializer.sv
// Parallel-to-serial output stage: captures NUM_LANES row words per handshake, emits them one per beat.
// Build macro ROW_SERIALIZER_DOUBLE_BUFFER_EN adds a shadow bank for zero-bubble back-to-back frames.
//  state | meaning
//  IDLE  | waiting for a frame, in_ready=1, out_valid=0
//  SEND  | presenting bank[idx] on out until the last lane is accepted
module row_serializer
    import row_serializer_pkg::*;
#(
    parameter int IO_DATA_WIDTH = DEFAULT_IO_DATA_WIDTH,
    parameter int NUM_LANES     = DEFAULT_NUM_LANES
) (
    input  logic                               clk,
    input  logic                               arst_n_in,
    input  logic [NUM_LANES*IO_DATA_WIDTH-1:0] in_words,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [IO_DATA_WIDTH-1:0]           out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic                               busy
);

    localparam int               IDX_W    = lane_idx_w(NUM_LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    state_e                   state;
    logic [IDX_W-1:0]         idx;
    logic [IO_DATA_WIDTH-1:0] rd_word;
    logic                     sending;
    logic                     beat;
    logic                     last_lane;
    logic                     capture;
    logic                     keep_sending;

    assign sending   = (state == SEND);
    assign beat      = sending && out_ready;
    assign last_lane = (idx == LAST_IDX);
    assign capture   = in_valid && in_ready;

`ifdef ROW_SERIALIZER_DOUBLE_BUFFER_EN
    // The two banks swap roles on handover instead of copying shadow into active.
    logic                     shadow_full;
    logic                     active_sel;
    logic                     shadow_load;
    logic                     active_load;
    logic                     handover;
    logic [IO_DATA_WIDTH-1:0] rd_word_0;
    logic [IO_DATA_WIDTH-1:0] rd_word_1;

    assign in_ready     = !shadow_full;
    assign handover     = beat && last_lane && shadow_full;
    assign shadow_load  = capture && sending && !(beat && last_lane);
    assign active_load  = capture && !shadow_load;
    assign keep_sending = shadow_full || capture;
    assign rd_word      = active_sel ? rd_word_1 : rd_word_0;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            shadow_full <= 1'b0;
            active_sel  <= 1'b0;
        end else if (handover) begin
            shadow_full <= 1'b0;
            active_sel  <= ~active_sel;
        end else if (shadow_load) begin
            shadow_full <= 1'b1;
        end
    end

    serializer_bank #(.IO_DATA_WIDTH(IO_DATA_WIDTH), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_bank_0 (
        .clk        (clk),
        .rst_n      (arst_n_in),
        .load       (active_sel ? shadow_load : active_load),
        .load_words (in_words),
        .sel        (idx),
        .rd_word    (rd_word_0)
    );

    serializer_bank #(.IO_DATA_WIDTH(IO_DATA_WIDTH), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_bank_1 (
        .clk        (clk),
        .rst_n      (arst_n_in),
        .load       (active_sel ? active_load : shadow_load),
        .load_words (in_words),
        .sel        (idx),
        .rd_word    (rd_word_1)
    );
`else
    assign in_ready     = !sending;
    assign keep_sending = 1'b0;

    serializer_bank #(.IO_DATA_WIDTH(IO_DATA_WIDTH), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_bank (
        .clk        (clk),
        .rst_n      (arst_n_in),
        .load       (capture),
        .load_words (in_words),
        .sel        (idx),
        .rd_word    (rd_word)
    );
`endif

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        state <= SEND;
                        idx   <= '0;
                    end
                end
                SEND: begin
                    if (beat) begin
                        if (last_lane) begin
                            idx <= '0;
                            if (!keep_sending) state <= IDLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign out_valid = sending;
    assign out       = sending ? rd_word : '0;
    assign out_last  = sending && last_lane;
    assign busy      = sending;

endmodule

// File: tb/tb_row_serializer.sv
// Self-checking bench for row_serializer: directed vector table plus hand-written corner sequences.
// Exercises the shadow-bank path when built with ROW_SERIALIZER_DOUBLE_BUFFER_EN.
module tb_row_serializer;

`ifdef ROW_SERIALIZER_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic [47:0] in_words;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    logic [15:0] in_words2;
    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  out2;
    logic        out_valid2;
    logic        out_ready2;
    logic        out_last2;
    logic        busy2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    row_serializer #(.IO_DATA_WIDTH(16), .NUM_LANES(3)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .in_words(in_words), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    row_serializer #(.IO_DATA_WIDTH(8), .NUM_LANES(2)) dut2 (
        .clk(clk), .arst_n_in(arst_n_in), .in_words(in_words2), .in_valid(in_valid2),
        .in_ready(in_ready2), .out(out2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_last(out_last2), .busy(busy2)
    );

    typedef struct {
        logic        iv;
        logic [47:0] w;
        logic        ordy;
        logic        eov;
        logic [15:0] eout;
        logic        elast;
        logic        eir;
        logic        ebusy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_main(input string tag, input logic eov, input logic [15:0] eout,
                            input logic elast, input logic eir, input logic ebusy);
        chk({tag, ".out_valid"}, 16'(out_valid), 16'(eov));
        chk({tag, ".out"},       out,            eout);
        chk({tag, ".out_last"},  16'(out_last),  16'(elast));
        chk({tag, ".in_ready"},  16'(in_ready),  16'(eir));
        chk({tag, ".busy"},      16'(busy),      16'(ebusy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_idle(input logic iv, input logic [47:0] w);
        vec_t v;
        v.iv = iv; v.w = w; v.ordy = 1'b1;
        v.eov = 1'b0; v.eout = 16'h0; v.elast = 1'b0; v.eir = 1'b1; v.ebusy = 1'b0;
        tbl.push_back(v);
    endtask

    task automatic add_send(input logic iv, input logic [47:0] w, input logic ordy,
                            input logic [15:0] eout, input logic elast);
        vec_t v;
        v.iv = iv; v.w = w; v.ordy = ordy;
        v.eov = 1'b1; v.eout = eout; v.elast = elast; v.eir = DB; v.ebusy = 1'b1;
        tbl.push_back(v);
    endtask

    initial begin
        arst_n_in = 1'b0;
        in_words  = '0;  in_valid  = 1'b0; out_ready  = 1'b1;
        in_words2 = '0;  in_valid2 = 1'b0; out_ready2 = 1'b1;

        // frame with out_ready held high; X words while idle must not reach out
        add_idle(1'b1, 48'h3333_2222_1111);
        add_send(1'b0, 'x, 1'b1, 16'h1111, 1'b0);
        add_send(1'b0, 'x, 1'b1, 16'h2222, 1'b0);
        add_send(1'b0, 'x, 1'b1, 16'h3333, 1'b1);
        add_idle(1'b0, 'x);
        // backpressure for three cycles on lane 1
        add_idle(1'b1, 48'h3333_2222_1111);
        add_send(1'b0, 'x, 1'b1, 16'h1111, 1'b0);
        add_send(1'b0, 'x, 1'b0, 16'h2222, 1'b0);
        add_send(1'b0, 'x, 1'b0, 16'h2222, 1'b0);
        add_send(1'b0, 'x, 1'b0, 16'h2222, 1'b0);
        add_send(1'b0, 'x, 1'b1, 16'h2222, 1'b0);
        add_send(1'b0, 'x, 1'b1, 16'h3333, 1'b1);
        add_idle(1'b0, 'x);
        if (!DB) begin
            // in_valid during SEND is ignored until IDLE
            add_idle(1'b1, 48'h3C3C_2B2B_1A1A);
            add_send(1'b1, 48'hDEAD_DEAD_DEAD, 1'b1, 16'h1A1A, 1'b0);
            add_send(1'b1, 48'hDEAD_DEAD_DEAD, 1'b1, 16'h2B2B, 1'b0);
            add_send(1'b1, 48'hDEAD_DEAD_DEAD, 1'b1, 16'h3C3C, 1'b1);
            add_idle(1'b1, 48'hDEAD_DEAD_DEAD);
            add_send(1'b0, 'x, 1'b1, 16'hDEAD, 1'b0);
            add_send(1'b0, 'x, 1'b1, 16'hDEAD, 1'b0);
            add_send(1'b0, 'x, 1'b1, 16'hDEAD, 1'b1);
            add_idle(1'b0, 'x);
        end

        #2;
        chk_main("reset", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        arst_n_in = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            in_valid  = tbl[i].iv;
            in_words  = tbl[i].w;
            out_ready = tbl[i].ordy;
            #1;
            chk_main($sformatf("vec%0d", i), tbl[i].eov, tbl[i].eout, tbl[i].elast, tbl[i].eir, tbl[i].ebusy);
            tick();
        end

        // asynchronous reset mid-frame after lane 0 was accepted
        in_valid = 1'b1; in_words = 48'h9999_8888_7777; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_words = 'x;
        #1 chk_main("rst_lane0", 1'b1, 16'h7777, 1'b0, DB, 1'b1);
        tick();
        #1 chk_main("rst_lane1", 1'b1, 16'h8888, 1'b0, DB, 1'b1);
        #1 arst_n_in = 1'b0;
        #1 chk_main("rst_async", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        #1 arst_n_in = 1'b1;
        tick();
        in_valid = 1'b1; in_words = 48'h0C0C_0B0B_0A0A;
        #1 chk_main("post_rst_idle", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0; in_words = 'x;
        #1 chk_main("post_rst_l0", 1'b1, 16'h0A0A, 1'b0, DB, 1'b1);
        tick();
        #1 chk_main("post_rst_l1", 1'b1, 16'h0B0B, 1'b0, DB, 1'b1);
        tick();
        #1 chk_main("post_rst_l2", 1'b1, 16'h0C0C, 1'b1, DB, 1'b1);
        tick();
        #1 chk_main("post_rst_end", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

`ifdef ROW_SERIALIZER_DOUBLE_BUFFER_EN
        // back-to-back frames through the shadow bank
        in_valid = 1'b1; in_words = 48'h0003_0002_0001; out_ready = 1'b1;
        #1 chk_main("db_idle", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        tick();
        in_words = 48'h0006_0005_0004;
        #1 chk_main("db_w1", 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0; in_words = 'x;
        #1 chk_main("db_w2", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
        tick();
        #1 chk_main("db_w3", 1'b1, 16'h0003, 1'b1, 1'b0, 1'b1);
        tick();
        #1 chk_main("db_w4", 1'b1, 16'h0004, 1'b0, 1'b1, 1'b1);
        tick();
        #1 chk_main("db_w5", 1'b1, 16'h0005, 1'b0, 1'b1, 1'b1);
        tick();
        #1 chk_main("db_w6", 1'b1, 16'h0006, 1'b1, 1'b1, 1'b1);
        tick();
        #1 chk_main("db_end", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
`endif

        // two-lane, 8-bit instance: lane order and idx wrap into the next frame
        in_valid2 = 1'b1; in_words2 = 16'h55AA; out_ready2 = 1'b1;
        #1 chk("n2_idle_ready", 16'(in_ready2), 16'h1);
        chk("n2_idle_valid", 16'(out_valid2), 16'h0);
        tick();
        in_valid2 = 1'b0; in_words2 = 'x;
        #1 chk("n2_f1_l0", {8'h0, out2}, 16'h00AA);
        chk("n2_f1_l0_last", 16'(out_last2), 16'h0);
        chk("n2_f1_l0_valid", 16'(out_valid2), 16'h1);
        tick();
        #1 chk("n2_f1_l1", {8'h0, out2}, 16'h0055);
        chk("n2_f1_l1_last", 16'(out_last2), 16'h1);
        tick();
        in_valid2 = 1'b1; in_words2 = 16'h3412;
        #1 chk("n2_gap_valid", 16'(out_valid2), 16'h0);
        chk("n2_gap_busy", 16'(busy2), 16'h0);
        tick();
        in_valid2 = 1'b0; in_words2 = 'x;
        #1 chk("n2_f2_l0", {8'h0, out2}, 16'h0012);
        chk("n2_f2_l0_last", 16'(out_last2), 16'h0);
        tick();
        #1 chk("n2_f2_l1", {8'h0, out2}, 16'h0034);
        chk("n2_f2_l1_last", 16'(out_last2), 16'h1);
        tick();
        #1 chk("n2_end_valid", 16'(out_valid2), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
